// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC hardwired control sequencer:
// opcode values, sequencer state encoding, ALU-op one-hot indices and
// small opcode classification helpers used by the output decoder.
package minisrc_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    localparam int ALU_W    = 13;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_MUL  = 2;
    localparam int ALU_DIV  = 3;
    localparam int ALU_SHR  = 4;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_ROR  = 7;
    localparam int ALU_ROL  = 8;
    localparam int ALU_AND  = 9;
    localparam int ALU_OR   = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef logic [ALU_W-1:0] alu_vec_t;

    // ALU operation named by the opcode itself (immediates map onto their base op).
    // Address arithmetic for ld/ldi/st/br always uses ADD and is decoded separately.
    function automatic alu_vec_t alu_sel(input logic [4:0] op);
        alu_vec_t v;
        v = '0;
        case (op)
            OP_ADD, OP_ADDI: v[ALU_ADD]  = 1'b1;
            OP_SUB:          v[ALU_SUB]  = 1'b1;
            OP_AND, OP_ANDI: v[ALU_AND]  = 1'b1;
            OP_OR,  OP_ORI:  v[ALU_OR]   = 1'b1;
            OP_ROR:          v[ALU_ROR]  = 1'b1;
            OP_ROL:          v[ALU_ROL]  = 1'b1;
            OP_SHR:          v[ALU_SHR]  = 1'b1;
            OP_SHRA:         v[ALU_SHRA] = 1'b1;
            OP_SHL:          v[ALU_SHL]  = 1'b1;
            OP_MUL:          v[ALU_MUL]  = 1'b1;
            OP_DIV:          v[ALU_DIV]  = 1'b1;
            OP_NEG:          v[ALU_NEG]  = 1'b1;
            OP_NOT:          v[ALU_NOT]  = 1'b1;
            default:         v = '0;
        endcase
        return v;
    endfunction

    function automatic logic is_alu3(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                          OP_SHR, OP_SHRA, OP_SHL};
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return op inside {OP_NEG, OP_NOT};
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return op inside {OP_LD, OP_LDI, OP_ST};
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: steps through fetch (T0-T2) and the
// per-opcode execute steps, decoding every datapath strobe from state+opcode.
//
// state  | meaning
// S_RST  | reset / first cycle after Clear, all outputs low
// S_T0   | fetch: PC to MAR, PC+1 into Z
// S_T1   | fetch: memory read into MDR, Z into PC (held MEM_WAIT extra cycles)
// S_T2   | fetch: MDR into IR; nop/halt finish here
// S_T3   | execute step 1 (illegal opcodes flag here)
// S_T4   | execute step 2
// S_T5   | execute step 3
// S_T6   | execute step 4 (ld read held MEM_WAIT extra cycles)
// S_T7   | execute step 5 (ld writeback)
// S_HALT | stopped, all outputs low until Clear
module control_unit
    import minisrc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic        Illegal,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        LOout,
    output logic        HIin,
    output logic        HIout,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        AND,
    output logic        OR,
    output logic        NEG,
    output logic        NOT
);

    localparam logic [2:0] WAIT_LD = MEM_WAIT[2:0];

    state_t     state;
    state_t     state_nxt;
    state_t     enter_t0;
    logic [2:0] wait_cnt;
    logic [4:0] opcode;
    logic       wait_done;
    logic       ends_at_t3;
    alu_vec_t   alu_vec;
    logic       unused_ir_bits;

    assign opcode         = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];
    assign wait_done      = (wait_cnt == 3'd0);

    // Opcodes with no execute step beyond T3: jumps, HI/LO moves and everything unsupported.
    assign ends_at_t3 = !(is_alu3(opcode) || is_imm(opcode) || is_muldiv(opcode) ||
                          is_unary(opcode) || is_mem(opcode) || (opcode == OP_BR));

    // Every instruction boundary honours Stop, so a pending stop lands in HALT instead of T0.
    assign enter_t0 = Stop ? S_HALT : S_T0;

    // State register with asynchronous clear.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-wait down-counter: reloads on every state change, counts down while a state is held.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            wait_cnt <= 3'd0;
        end else if (state_nxt != state) begin
            wait_cnt <= WAIT_LD;
        end else if (!wait_done) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST: state_nxt = enter_t0;
            S_T0:  state_nxt = S_T1;
            S_T1:  state_nxt = wait_done ? S_T2 : S_T1;
            S_T2: begin
                if (opcode == OP_NOP) begin
                    state_nxt = enter_t0;
                end else if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_T3;
                end
            end
            S_T3:  state_nxt = ends_at_t3 ? enter_t0 : S_T4;
            S_T4:  state_nxt = is_unary(opcode) ? enter_t0 : S_T5;
            S_T5: begin
                if (is_alu3(opcode) || is_imm(opcode) || (opcode == OP_LDI)) begin
                    state_nxt = enter_t0;
                end else begin
                    state_nxt = S_T6;
                end
            end
            S_T6: begin
                if (opcode == OP_LD) begin
                    state_nxt = wait_done ? S_T7 : S_T6;
                end else begin
                    state_nxt = enter_t0;
                end
            end
            S_T7:   state_nxt = enter_t0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // Moore output decode; fetch steps ignore IR so a changing IR cannot glitch them.
    always_comb begin
        Illegal  = 1'b0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        LOout    = 1'b0;
        HIin     = 1'b0;
        HIout    = 1'b0;
        CONin    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        Cout     = 1'b0;
        alu_vec  = '0;
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_alu3(opcode) || is_imm(opcode)) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv(opcode)) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary(opcode)) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_vec = alu_sel(opcode);
                end else if (is_mem(opcode)) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (opcode == OP_BR) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (opcode == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (opcode == OP_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu3(opcode)) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_vec = alu_sel(opcode);
                end else if (is_imm(opcode)) begin
                    Cout = 1'b1; Zin = 1'b1; alu_vec = alu_sel(opcode);
                end else if (is_muldiv(opcode)) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_vec = alu_sel(opcode);
                end else if (is_unary(opcode)) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mem(opcode)) begin
                    Cout = 1'b1; Zin = 1'b1; alu_vec[ALU_ADD] = 1'b1;
                end else if (opcode == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu3(opcode) || is_imm(opcode) || (opcode == OP_LDI)) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv(opcode)) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (opcode == OP_BR) begin
                    Cout = 1'b1; Zin = 1'b1; alu_vec[ALU_ADD] = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv(opcode)) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (opcode == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (opcode == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; Write = 1'b1;
                end else if (opcode == OP_BR) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end
            end
            S_T7: begin
                if (opcode == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: begin
                Illegal = 1'b0;
            end
        endcase
    end

    assign Run  = (state != S_RST) && (state != S_HALT);

    assign ADD  = alu_vec[ALU_ADD];
    assign SUB  = alu_vec[ALU_SUB];
    assign MUL  = alu_vec[ALU_MUL];
    assign DIV  = alu_vec[ALU_DIV];
    assign SHR  = alu_vec[ALU_SHR];
    assign SHRA = alu_vec[ALU_SHRA];
    assign SHL  = alu_vec[ALU_SHL];
    assign ROR  = alu_vec[ALU_ROR];
    assign ROL  = alu_vec[ALU_ROL];
    assign AND  = alu_vec[ALU_AND];
    assign OR   = alu_vec[ALU_OR];
    assign NEG  = alu_vec[ALU_NEG];
    assign NOT  = alu_vec[ALU_NOT];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model builds the
// expected per-cycle output vector list for each instruction, and a single
// compare process checks every cycle's outputs against that list.
module tb_control_unit;

    localparam int MW = 2;

    typedef logic [39:0] vec_t;

    localparam vec_t M_RUN      = 40'd1 << 0;
    localparam vec_t M_ILLEGAL  = 40'd1 << 1;
    localparam vec_t M_PCOUT    = 40'd1 << 2;
    localparam vec_t M_PCIN     = 40'd1 << 3;
    localparam vec_t M_INCPC    = 40'd1 << 4;
    localparam vec_t M_MARIN    = 40'd1 << 5;
    localparam vec_t M_MDRIN    = 40'd1 << 6;
    localparam vec_t M_MDROUT   = 40'd1 << 7;
    localparam vec_t M_READ     = 40'd1 << 8;
    localparam vec_t M_WRITE    = 40'd1 << 9;
    localparam vec_t M_IRIN     = 40'd1 << 10;
    localparam vec_t M_YIN      = 40'd1 << 11;
    localparam vec_t M_ZIN      = 40'd1 << 12;
    localparam vec_t M_ZLOWOUT  = 40'd1 << 13;
    localparam vec_t M_ZHIGHOUT = 40'd1 << 14;
    localparam vec_t M_LOIN     = 40'd1 << 15;
    localparam vec_t M_LOOUT    = 40'd1 << 16;
    localparam vec_t M_HIIN     = 40'd1 << 17;
    localparam vec_t M_HIOUT    = 40'd1 << 18;
    localparam vec_t M_CONIN    = 40'd1 << 19;
    localparam vec_t M_GRA      = 40'd1 << 20;
    localparam vec_t M_GRB      = 40'd1 << 21;
    localparam vec_t M_GRC      = 40'd1 << 22;
    localparam vec_t M_RIN      = 40'd1 << 23;
    localparam vec_t M_ROUT     = 40'd1 << 24;
    localparam vec_t M_BAOUT    = 40'd1 << 25;
    localparam vec_t M_COUT     = 40'd1 << 26;
    localparam vec_t M_ADD      = 40'd1 << 27;
    localparam vec_t M_SUB      = 40'd1 << 28;
    localparam vec_t M_MUL      = 40'd1 << 29;
    localparam vec_t M_DIV      = 40'd1 << 30;
    localparam vec_t M_SHR      = 40'd1 << 31;
    localparam vec_t M_SHRA     = 40'd1 << 32;
    localparam vec_t M_SHL      = 40'd1 << 33;
    localparam vec_t M_ROR      = 40'd1 << 34;
    localparam vec_t M_ROL      = 40'd1 << 35;
    localparam vec_t M_AND      = 40'd1 << 36;
    localparam vec_t M_OR       = 40'd1 << 37;
    localparam vec_t M_NEG      = 40'd1 << 38;
    localparam vec_t M_NOT      = 40'd1 << 39;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Stop = 1'b0;
    logic        CON_FF = 1'b0;
    logic [31:0] IR = 32'h0;
    logic Run, Illegal, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic Yin, Zin, Zlowout, Zhighout, LOin, LOout, HIin, HIout, CONin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT;

    vec_t act;
    vec_t exp_v;
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   started = 1'b0;

    always #5 Clock = ~Clock;

    control_unit #(.MEM_WAIT(MW)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .Illegal(Illegal), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOin(LOin), .LOout(LOout), .HIin(HIin), .HIout(HIout), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR),
        .NEG(NEG), .NOT(NOT)
    );

    assign act = {NOT, NEG, OR, AND, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD,
                  Cout, BAout, Rout, Rin, Grc, Grb, Gra, CONin, HIout, HIin, LOout,
                  LOin, Zhighout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin,
                  MARin, IncPC, PCin, PCout, Illegal, Run};

    task automatic check_vec(input string name, input vec_t got, input vec_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Compare process: one expected vector per clock cycle.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_vec("outputs", act, exp_v);
        end else if (started) begin
            n_vec++;
            n_bad++;
            $display("FAIL expectation underflow at %0t: outputs=%h", $time, act);
        end
    end

    function automatic vec_t op_mask(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return M_ADD;
            5'd4:        return M_SUB;
            5'd5, 5'd13: return M_AND;
            5'd6, 5'd14: return M_OR;
            5'd7:        return M_ROR;
            5'd8:        return M_ROL;
            5'd9:        return M_SHR;
            5'd10:       return M_SHRA;
            5'd11:       return M_SHL;
            5'd15:       return M_MUL;
            5'd16:       return M_DIV;
            5'd17:       return M_NEG;
            5'd18:       return M_NOT;
            default:     return '0;
        endcase
    endfunction

    // Instruction-level model: list of step strobe sets, Run high in every step.
    task automatic push_instr(input logic [4:0] op, input logic con, input int lim,
                              output int len, output logic halts);
        vec_t s[$];
        vec_t a;
        s = {};
        a = op_mask(op);
        halts = 1'b0;
        s.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        for (int i = 0; i <= MW; i++) s.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
        s.push_back(M_MDROUT | M_IRIN);
        case (op) inside
            [5'd3:5'd11]: begin
                s.push_back(M_GRB | M_ROUT | M_YIN);
                s.push_back(M_GRC | M_ROUT | a | M_ZIN);
                s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            [5'd12:5'd14]: begin
                s.push_back(M_GRB | M_ROUT | M_YIN);
                s.push_back(M_COUT | a | M_ZIN);
                s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'd15, 5'd16: begin
                s.push_back(M_GRA | M_ROUT | M_YIN);
                s.push_back(M_GRB | M_ROUT | a | M_ZIN);
                s.push_back(M_ZLOWOUT | M_LOIN);
                s.push_back(M_ZHIGHOUT | M_HIIN);
            end
            5'd17, 5'd18: begin
                s.push_back(M_GRB | M_ROUT | a | M_ZIN);
                s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'd0, 5'd1, 5'd2: begin
                s.push_back(M_GRB | M_BAOUT | M_YIN);
                s.push_back(M_COUT | M_ADD | M_ZIN);
                if (op == 5'd1) begin
                    s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
                end else begin
                    s.push_back(M_ZLOWOUT | M_MARIN);
                    if (op == 5'd0) begin
                        for (int i = 0; i <= MW; i++) s.push_back(M_READ | M_MDRIN);
                        s.push_back(M_MDROUT | M_GRA | M_RIN);
                    end else begin
                        s.push_back(M_GRA | M_ROUT | M_WRITE);
                    end
                end
            end
            5'd19: begin
                s.push_back(M_GRA | M_ROUT | M_CONIN);
                s.push_back(M_PCOUT | M_YIN);
                s.push_back(M_COUT | M_ADD | M_ZIN);
                s.push_back(M_ZLOWOUT | (con ? M_PCIN : '0));
            end
            5'd20: s.push_back(M_GRA | M_ROUT | M_PCIN);
            5'd24: s.push_back(M_HIOUT | M_GRA | M_RIN);
            5'd25: s.push_back(M_LOOUT | M_GRA | M_RIN);
            5'd26: ;
            5'd27: halts = 1'b1;
            default: s.push_back(M_ILLEGAL);
        endcase
        len = (lim > 0 && lim < s.size()) ? lim : s.size();
        for (int i = 0; i < len; i++) exp_q.push_back(s[i] | M_RUN);
    endtask

    // Called just after a rising edge; leaves the DUT one edge past release, i.e. in T0.
    task automatic do_clear(input int k);
        started = 1'b1;
        Clear = 1'b1;
        Stop = 1'b0;
        for (int i = 0; i <= k; i++) exp_q.push_back('0);
        repeat (k) @(posedge Clock);
        #1 Clear = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    // Called just after the rising edge that enters T0; returns just after the next T0 edge.
    task automatic run_instr(input logic [31:0] ir, input logic con, input logic stp,
                             output int len, output int reads, output int ills);
        logic h;
        IR = ir;
        CON_FF = con;
        Stop = stp;
        push_instr(ir[31:27], con, 0, len, h);
        reads = 0;
        ills = 0;
        repeat (len) begin
            @(negedge Clock);
            #1;
            reads += int'(Read);
            ills += int'(Illegal);
        end
        @(posedge Clock);
        #1;
        if (h || stp) begin
            Stop = 1'b0;
            for (int i = 0; i < 20; i++) exp_q.push_back('0);
            repeat (20) @(posedge Clock);
            #1;
            do_clear(2);
        end
    endtask

    initial begin
        int len, reads, ills;
        logic hh;
        logic [4:0] op;
        @(posedge Clock);
        #1;
        do_clear(3);

        run_instr(32'h18918000, 1'b0, 1'b0, len, reads, ills);
        check_int("add_len", len, 8);
        check_int("add_reads", reads, MW + 1);
        check_int("add_illegal", ills, 0);

        run_instr(32'h98800000, 1'b0, 1'b0, len, reads, ills);
        check_int("br_len", len, 9);
        run_instr(32'h98800000, 1'b1, 1'b0, len, reads, ills);

        run_instr(32'h00880004, 1'b0, 1'b0, len, reads, ills);
        check_int("ld_len", len, 12);
        check_int("ld_reads", reads, 6);

        run_instr(32'hD8000000, 1'b0, 1'b0, len, reads, ills);
        check_int("halt_len", len, 5);

        run_instr(32'h18918000, 1'b0, 1'b1, len, reads, ills);

        IR = 32'h78918000;
        CON_FF = 1'b0;
        push_instr(5'd15, 1'b0, MW + 5, len, hh);
        repeat (len - 1) @(posedge Clock);
        @(negedge Clock);
        #2 Clear = 1'b1;
        #1;
        check_int("midclear_mul", int'(MUL), 0);
        check_int("midclear_zin", int'(Zin), 0);
        check_vec("midclear_all", act, '0);
        @(posedge Clock);
        #1;
        do_clear(3);

        run_instr(32'hA8000000, 1'b0, 1'b0, len, reads, ills);
        check_int("jal_illegal", ills, 1);
        check_int("jal_len", len, 6);

        for (int n = 0; n < 150; n++) begin
            op = 5'($urandom_range(0, 31));
            run_instr({op, 27'($urandom())}, 1'($urandom()), ($urandom_range(0, 11) == 0),
                      len, reads, ills);
            check_int("rand_illegal", ills,
                      (op inside {5'd21, 5'd22, 5'd23, [5'd28:5'd31]}) ? 1 : 0);
            check_int("rand_reads", reads, (op == 5'd0) ? 2 * (MW + 1) : MW + 1);
        end

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
